// File: rtl/vga_pkg.sv
// Shared timing defaults, test-pattern encoding and colour-bar palette for the
// VGA raster generator.
package vga_pkg;

  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FRONT  = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BACK   = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FRONT  = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BACK   = 33;

  typedef enum logic [1:0] {
    PAT_WHITE = 2'd0,
    PAT_BARS  = 2'd1,
    PAT_CHECK = 2'd2,
    PAT_BLACK = 2'd3
  } pattern_e;

  // Each entry is {red, green, blue} on/off; entry 0 is the leftmost bar
  localparam logic [7:0][2:0] BAR_COLORS = {
    3'b000,  // black
    3'b001,  // blue
    3'b100,  // red
    3'b101,  // magenta
    3'b010,  // green
    3'b011,  // cyan
    3'b110,  // yellow
    3'b111   // white
  };

  function automatic logic [2:0] barColor(input logic [2:0] idx);
    return BAR_COLORS[idx];
  endfunction

endpackage

// File: rtl/vga_pixel_strobe.sv
// Pixel clock-enable: a single-cycle strobe every CLK_DIV system clocks, held
// low while reset is asserted.
module vga_pixel_strobe #(
  parameter int CLK_DIV = 2
) (
  input  logic clk,
  input  logic rst,
  output logic pix_ce
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] r_div;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_div <= '0;
    end else if (r_div == DIV_LAST) begin
      r_div <= '0;
    end else begin
      r_div <= r_div + DIV_W'(1);
    end
  end

  // Masking with rst lets a divide-by-1 build strobe on the very first edge after release
  assign pix_ce = ~rst & (r_div == DIV_LAST);

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator with built-in test patterns; every video output is
// registered on the pixel strobe so sync, de, coordinates and RGB stay aligned.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int H_ACTIVE   = DEF_H_ACTIVE,
  parameter int H_FRONT    = DEF_H_FRONT,
  parameter int H_SYNC     = DEF_H_SYNC,
  parameter int H_BACK     = DEF_H_BACK,
  parameter int V_ACTIVE   = DEF_V_ACTIVE,
  parameter int V_FRONT    = DEF_V_FRONT,
  parameter int V_SYNC     = DEF_V_SYNC,
  parameter int V_BACK     = DEF_V_BACK,
  parameter int CLK_DIV    = 2,
  parameter bit HSYNC_POL  = 1'b0,
  parameter bit VSYNC_POL  = 1'b0,
  parameter int CNT_W      = 11,
  parameter int COLOR_W    = 8,
  parameter int CHECK_LOG2 = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [1:0]         pattern_sel,
  output logic               pix_ce,
  output logic               hsync,
  output logic               vsync,
  output logic               de,
  output logic               blank_n,
  output logic               sync_n,
  output logic [CNT_W-1:0]   x,
  output logic [CNT_W-1:0]   y,
  output logic               line_start,
  output logic               frame_start,
  output logic [COLOR_W-1:0] red,
  output logic [COLOR_W-1:0] green,
  output logic [COLOR_W-1:0] blue
);

  localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;
  localparam int BAR_W   = H_ACTIVE / 8;

  localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_ACT    = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] V_ACT    = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] HS_START = CNT_W'(H_ACTIVE + H_FRONT);
  localparam logic [CNT_W-1:0] HS_END   = CNT_W'(H_ACTIVE + H_FRONT + H_SYNC);
  localparam logic [CNT_W-1:0] VS_START = CNT_W'(V_ACTIVE + V_FRONT);
  localparam logic [CNT_W-1:0] VS_END   = CNT_W'(V_ACTIVE + V_FRONT + V_SYNC);
  localparam logic [CNT_W-1:0] BAR_LAST = CNT_W'(BAR_W - 1);

  logic             w_pixCe;
  logic [CNT_W-1:0] r_h;
  logic [CNT_W-1:0] r_v;
  logic [CNT_W-1:0] r_barSub;
  logic [2:0]       r_barIdx;
  pattern_e         r_pat;

  logic     w_hWrap;
  logic     w_vWrap;
  logic     w_de;
  logic     w_hSyncOn;
  logic     w_vSyncOn;
  logic     w_frameTop;
  logic     w_checkOdd;
  pattern_e w_pat;
  logic [2:0] w_rgb3;

  vga_pixel_strobe #(
    .CLK_DIV(CLK_DIV)
  ) u_strobe (
    .clk    (clk),
    .rst    (rst),
    .pix_ce (w_pixCe)
  );

  assign pix_ce  = w_pixCe;
  assign blank_n = de;
  assign sync_n  = 1'b1;

  assign w_hWrap    = (r_h == H_LAST);
  assign w_vWrap    = (r_v == V_LAST);
  assign w_de       = (r_h < H_ACT) && (r_v < V_ACT);
  assign w_hSyncOn  = (r_h >= HS_START) && (r_h < HS_END);
  assign w_vSyncOn  = (r_v >= VS_START) && (r_v < VS_END);
  assign w_frameTop = (r_h == '0) && (r_v == '0);
  assign w_checkOdd = r_h[CHECK_LOG2] ^ r_v[CHECK_LOG2];

  // The first pixel of a frame already shows the newly requested pattern
  assign w_pat = w_frameTop ? pattern_e'(pattern_sel) : r_pat;

  always_comb begin
    w_rgb3 = 3'b000;
    case (w_pat)
      PAT_WHITE: w_rgb3 = 3'b111;
      PAT_BARS:  w_rgb3 = barColor(r_barIdx);
      PAT_CHECK: w_rgb3 = w_checkOdd ? 3'b000 : 3'b111;
      default:   w_rgb3 = 3'b000;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_h         <= '0;
      r_v         <= '0;
      r_barSub    <= '0;
      r_barIdx    <= '0;
      r_pat       <= PAT_WHITE;
      hsync       <= ~HSYNC_POL;
      vsync       <= ~VSYNC_POL;
      de          <= 1'b0;
      x           <= '0;
      y           <= '0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      red         <= '0;
      green       <= '0;
      blue        <= '0;
    end else if (w_pixCe) begin
      r_h <= w_hWrap ? '0 : r_h + CNT_W'(1);
      if (w_hWrap) begin
        r_v <= w_vWrap ? '0 : r_v + CNT_W'(1);
      end

      // Bar index tracks r_h without a divide; it keeps spinning through blanking harmlessly
      if (w_hWrap) begin
        r_barSub <= '0;
        r_barIdx <= '0;
      end else if (r_barSub == BAR_LAST) begin
        r_barSub <= '0;
        r_barIdx <= r_barIdx + 3'd1;
      end else begin
        r_barSub <= r_barSub + CNT_W'(1);
      end

      if (w_frameTop) begin
        r_pat <= pattern_e'(pattern_sel);
      end

      hsync       <= w_hSyncOn ? HSYNC_POL : ~HSYNC_POL;
      vsync       <= w_vSyncOn ? VSYNC_POL : ~VSYNC_POL;
      de          <= w_de;
      x           <= w_de ? r_h : '0;
      y           <= w_de ? r_v : '0;
      line_start  <= (r_h == '0) && (r_v < V_ACT);
      frame_start <= w_frameTop;
      red         <= {COLOR_W{w_de & w_rgb3[2]}};
      green       <= {COLOR_W{w_de & w_rgb3[1]}};
      blue        <= {COLOR_W{w_de & w_rgb3[0]}};
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Runs three generator builds side by side against a raster model that derives every
// output from the number of clocks elapsed since reset.
module tb_vga_timing_gen;

  localparam int NI = 3;
  localparam int NCYC = 40000;

  localparam int C_HA[NI]   = '{64, 40, 640};
  localparam int C_HF[NI]   = '{4, 2, 16};
  localparam int C_HS[NI]   = '{8, 4, 96};
  localparam int C_HB[NI]   = '{4, 2, 48};
  localparam int C_VA[NI]   = '{48, 20, 480};
  localparam int C_VF[NI]   = '{2, 1, 10};
  localparam int C_VS[NI]   = '{2, 2, 2};
  localparam int C_VB[NI]   = '{3, 2, 33};
  localparam int C_DIV[NI]  = '{2, 1, 2};
  localparam bit C_HPOL[NI] = '{1'b0, 1'b1, 1'b0};
  localparam bit C_VPOL[NI] = '{1'b0, 1'b1, 1'b0};
  localparam int C_CHK[NI]  = '{3, 2, 5};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rstI[NI];
  logic [1:0] selI[NI];
  logic       pixCeO[NI];
  logic       hsyncO[NI];
  logic       vsyncO[NI];
  logic       deO[NI];
  logic       blankNO[NI];
  logic       syncNO[NI];
  logic [10:0] xO[NI];
  logic [10:0] yO[NI];
  logic       lineStartO[NI];
  logic       frameStartO[NI];
  logic [7:0] redO[NI];
  logic [7:0] greenO[NI];
  logic [7:0] blueO[NI];

  int         kCnt[NI];
  logic [1:0] patM[NI];
  bit         valid[NI];
  bit         litArm[NI];
  int         rstLeft[NI];
  int         assertCount = 0;
  int         failCount = 0;

  for (genvar g = 0; g < NI; g++) begin : gi
    vga_timing_gen #(
      .H_ACTIVE(C_HA[g]), .H_FRONT(C_HF[g]), .H_SYNC(C_HS[g]), .H_BACK(C_HB[g]),
      .V_ACTIVE(C_VA[g]), .V_FRONT(C_VF[g]), .V_SYNC(C_VS[g]), .V_BACK(C_VB[g]),
      .CLK_DIV(C_DIV[g]), .HSYNC_POL(C_HPOL[g]), .VSYNC_POL(C_VPOL[g]),
      .CNT_W(11), .COLOR_W(8), .CHECK_LOG2(C_CHK[g])
    ) dut (
      .clk         (clk),
      .rst         (rstI[g]),
      .pattern_sel (selI[g]),
      .pix_ce      (pixCeO[g]),
      .hsync       (hsyncO[g]),
      .vsync       (vsyncO[g]),
      .de          (deO[g]),
      .blank_n     (blankNO[g]),
      .sync_n      (syncNO[g]),
      .x           (xO[g]),
      .y           (yO[g]),
      .line_start  (lineStartO[g]),
      .frame_start (frameStartO[g]),
      .red         (redO[g]),
      .green       (greenO[g]),
      .blue        (blueO[g])
    );
  end

  function automatic int hTot(input int i);
    return C_HA[i] + C_HF[i] + C_HS[i] + C_HB[i];
  endfunction

  function automatic int vTot(input int i);
    return C_VA[i] + C_VF[i] + C_VS[i] + C_VB[i];
  endfunction

  function automatic logic [23:0] barRgb(input int bar);
    case (bar)
      0: return 24'hFFFFFF;
      1: return 24'hFFFF00;
      2: return 24'h00FFFF;
      3: return 24'h00FF00;
      4: return 24'hFF00FF;
      5: return 24'hFF0000;
      6: return 24'h0000FF;
      default: return 24'h000000;
    endcase
  endfunction

  function automatic logic [23:0] colorOf(input int i, input logic [1:0] pat, input int h, input int v);
    case (pat)
      2'd0: return 24'hFFFFFF;
      2'd1: return barRgb(h / (C_HA[i] / 8));
      2'd2: return ((((h >> C_CHK[i]) ^ (v >> C_CHK[i])) & 1) != 0) ? 24'h000000 : 24'hFFFFFF;
      default: return 24'h000000;
    endcase
  endfunction

  // Model clock: counts edges since reset and captures the pattern at each frame's first pixel
  always @(posedge clk) begin
    for (int i = 0; i < NI; i++) begin
      if (rstI[i]) begin
        kCnt[i]  <= 0;
        patM[i]  <= 2'd0;
        valid[i] <= 1'b1;
      end else if (valid[i]) begin
        if ((kCnt[i] % C_DIV[i] == C_DIV[i] - 1) &&
            ((kCnt[i] / C_DIV[i]) % (hTot(i) * vTot(i)) == 0)) begin
          patM[i] <= selI[i];
        end
        kCnt[i] <= kCnt[i] + 1;
      end
    end
  end

  task automatic checkOutput(input string name, input int inst, input logic [31:0] act,
                             input logic [31:0] exp);
    assertCount++;
    if (act !== exp) begin
      failCount++;
      $display("[TB] FAIL %s inst%0d k=%0d actual=%0h required=%0h", name, inst, kCnt[inst], act, exp);
    end
  endtask

  task automatic compareInst(input int i);
    int k, d, n, p, h, v, ht, vt;
    logic ePix, eHs, eVs, eDe, eLs, eFs;
    logic [31:0] eX, eY;
    logic [23:0] eRgb, aRgb;
    k = kCnt[i];
    d = C_DIV[i];
    ht = hTot(i);
    vt = vTot(i);
    n = k / d;
    ePix = !rstI[i] && (k % d == d - 1);
    eHs = !C_HPOL[i];
    eVs = !C_VPOL[i];
    eDe = 1'b0;
    eX = 0;
    eY = 0;
    eLs = 1'b0;
    eFs = 1'b0;
    eRgb = 24'h0;
    if (n > 0) begin
      p = n - 1;
      h = p % ht;
      v = (p / ht) % vt;
      if (h >= C_HA[i] + C_HF[i] && h < C_HA[i] + C_HF[i] + C_HS[i]) eHs = C_HPOL[i];
      if (v >= C_VA[i] + C_VF[i] && v < C_VA[i] + C_VF[i] + C_VS[i]) eVs = C_VPOL[i];
      eDe = (h < C_HA[i]) && (v < C_VA[i]);
      if (eDe) begin
        eX = h;
        eY = v;
        eRgb = colorOf(i, patM[i], h, v);
      end
      eLs = (h == 0) && (v < C_VA[i]);
      eFs = (h == 0) && (v == 0);
    end
    aRgb = {redO[i], greenO[i], blueO[i]};
    checkOutput("pix_ce", i, 32'(pixCeO[i]), 32'(ePix));
    checkOutput("hsync", i, 32'(hsyncO[i]), 32'(eHs));
    checkOutput("vsync", i, 32'(vsyncO[i]), 32'(eVs));
    checkOutput("de", i, 32'(deO[i]), 32'(eDe));
    checkOutput("blank_n", i, 32'(blankNO[i]), 32'(eDe));
    checkOutput("sync_n", i, 32'(syncNO[i]), 32'd1);
    checkOutput("x", i, 32'(xO[i]), eX);
    checkOutput("y", i, 32'(yO[i]), eY);
    checkOutput("line_start", i, 32'(lineStartO[i]), 32'(eLs));
    checkOutput("frame_start", i, 32'(frameStartO[i]), 32'(eFs));
    checkOutput("rgb", i, 32'(aRgb), 32'(eRgb));

    // Hand-computed pins on the default 640x480 build showing colour bars
    if (i == 2 && litArm[2]) begin
      case (k)
        1: checkOutput("lit_pixce_hi", i, 32'(pixCeO[i]), 32'd1);
        2: begin
          checkOutput("lit_pixce_lo", i, 32'(pixCeO[i]), 32'd0);
          checkOutput("lit_fs00", i, 32'(frameStartO[i]), 32'd1);
          checkOutput("lit_bar_x0", i, 32'(aRgb), 32'hFFFFFF);
        end
        160: checkOutput("lit_bar_x79", i, 32'(aRgb), 32'hFFFFFF);
        162: checkOutput("lit_bar_x80", i, 32'(aRgb), 32'hFFFF00);
        802: checkOutput("lit_bar_x400", i, 32'(aRgb), 32'hFF0000);
        1122: begin
          checkOutput("lit_bar_x560", i, 32'(aRgb), 32'h000000);
          checkOutput("lit_de_x560", i, 32'(deO[i]), 32'd1);
        end
        1282: checkOutput("lit_de_x640", i, 32'(deO[i]), 32'd0);
        1312: checkOutput("lit_hs_655", i, 32'(hsyncO[i]), 32'd1);
        1314: checkOutput("lit_hs_656", i, 32'(hsyncO[i]), 32'd0);
        1504: checkOutput("lit_hs_751", i, 32'(hsyncO[i]), 32'd0);
        1506: checkOutput("lit_hs_752", i, 32'(hsyncO[i]), 32'd1);
        1602: begin
          checkOutput("lit_ls_y1", i, 32'(lineStartO[i]), 32'd1);
          checkOutput("lit_y1", i, 32'(yO[i]), 32'd1);
        end
        default: ;
      endcase
    end

    // Small build: checkerboard in its first frame plus vertical sync edges
    if (i == 0 && litArm[0]) begin
      case (k)
        2:    checkOutput("lit_chk_0_0", i, 32'(aRgb), 32'hFFFFFF);
        18:   checkOutput("lit_chk_8_0", i, 32'(aRgb), 32'h000000);
        1298: checkOutput("lit_chk_8_8", i, 32'(aRgb), 32'hFFFFFF);
        8002: checkOutput("lit_vs_50", i, 32'(vsyncO[i]), 32'd0);
        8322: checkOutput("lit_vs_52", i, 32'(vsyncO[i]), 32'd1);
        default: ;
      endcase
    end

    // Divide-by-1 build with inverted syncs: state right after every reset release
    if (i == 1 && !rstI[1]) begin
      if (k == 0) begin
        checkOutput("lit_rst_hsync", i, 32'(hsyncO[i]), 32'd0);
        checkOutput("lit_rst_de", i, 32'(deO[i]), 32'd0);
        checkOutput("lit_rst_x", i, 32'(xO[i]), 32'd0);
        checkOutput("lit_rst_pixce", i, 32'(pixCeO[i]), 32'd1);
      end else if (k == 1) begin
        checkOutput("lit_fs_after_rst", i, 32'(frameStartO[i]), 32'd1);
        checkOutput("lit_x_after_rst", i, 32'(xO[i]), 32'd0);
        checkOutput("lit_y_after_rst", i, 32'(yO[i]), 32'd0);
        checkOutput("lit_vs_after_rst", i, 32'(vsyncO[i]), 32'd0);
      end
    end
  endtask

  // Outputs are stable mid-period, so every build is compared on the falling edge
  always @(negedge clk) begin
    for (int i = 0; i < NI; i++) begin
      if (valid[i]) compareInst(i);
    end
  end

  task automatic applyStimulus(input int t);
    @(posedge clk);
    #2;
    if (t > 20 && $urandom_range(0, 699) == 0) selI[0] = 2'($urandom_range(0, 3));
    if (t == 20000) begin
      litArm[0] = 1'b0;
      rstLeft[0] = 3;
    end
    if (t > 50 && rstLeft[1] == 0 && $urandom_range(0, 899) == 0) rstLeft[1] = $urandom_range(1, 3);
    if ($urandom_range(0, 299) == 0) selI[1] = 2'($urandom_range(0, 3));
    for (int i = 0; i < 2; i++) begin
      if (rstLeft[i] > 0) begin
        rstI[i] = 1'b1;
        rstLeft[i]--;
      end else begin
        rstI[i] = 1'b0;
      end
    end
  endtask

  initial begin
    for (int i = 0; i < NI; i++) begin
      rstI[i] = 1'b1;
      litArm[i] = 1'b1;
      rstLeft[i] = 0;
    end
    selI[0] = 2'd2;
    selI[1] = 2'd0;
    selI[2] = 2'd1;
    repeat (3) @(posedge clk);
    #2;
    for (int i = 0; i < NI; i++) rstI[i] = 1'b0;
    $display("[TB] reset released, running %0d cycles", NCYC);
    for (int t = 0; t < NCYC; t++) applyStimulus(t);
    repeat (2) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
